// File: rtl/clk_div_prog.sv
// Programmable clock divider: runtime period/high-time, a 50 %-duty output
// for both even and odd ratios, and a once-per-period tick. New settings are
// staged as "pending" and only take effect at a period boundary, or on the
// next edge while the divider is disabled.
module clk_div_prog #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 32,
  parameter int DEFAULT_HIGH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0] high_val,
  output logic             clk_out,
  output logic             clk_out_50,
  output logic             tick,
  output logic             pend,
  output logic             err
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic [WIDTH-1:0] phigh_q, phigh_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             p50_q, p50_d;
  logic             n50_q;

  logic             wrap;
  logic [WIDTH:0]   half_d;

  // Last legal count of the period; >= keeps the counter safe if it ever
  // sits beyond a freshly shortened period.
  assign wrap   = (cnt_q >= (div_q - ONE));
  // ceil(div/2), one bit wider so the +1 cannot overflow.
  assign half_d = ({1'b0, div_d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

  // Next-state: counting, boundary apply, disabled apply and load capture.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    high_d    = high_q;
    pdiv_d    = pdiv_q;
    phigh_d   = phigh_q;
    pend_d    = pend_q;
    err_d     = err_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    p50_d     = p50_q;

    if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pend_q) begin
          div_d  = pdiv_q;
          high_d = phigh_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
      // Outputs follow the count being entered, using any just-applied setting.
      clk_out_d = (cnt_d < high_d);
      p50_d     = ({1'b0, cnt_d} < half_d);
    end else if (pend_q) begin
      // Disabled: apply immediately and park at the end of the new period so
      // the next enabled edge starts a clean period.
      div_d     = pdiv_q;
      high_d    = phigh_q;
      pend_d    = 1'b0;
      cnt_d     = pdiv_q - ONE;
      clk_out_d = 1'b0;
      p50_d     = 1'b0;
    end

    // Loads are evaluated after the apply so a same-edge load stays pending.
    if (load) begin
      if (div_val >= TWO) begin
        pdiv_d  = div_val;
        phigh_d = (high_val > (div_val - ONE)) ? (div_val - ONE) : high_val;
        pend_d  = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Rising-edge state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= DIV_RST - ONE;
      div_q     <= DIV_RST;
      high_q    <= HIGH_RST;
      pdiv_q    <= DIV_RST;
      phigh_q   <= HIGH_RST;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      p50_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      pdiv_q    <= pdiv_d;
      phigh_q   <= phigh_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      p50_q     <= p50_d;
    end
  end

  // Half-cycle delayed copy of p50; ANDing it in trims half a cycle off the
  // high phase so odd ratios come out at exactly 50 %.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      n50_q <= 1'b0;
    end else begin
      n50_q <= p50_q;
    end
  end

  assign clk_out    = clk_out_q;
  assign clk_out_50 = div_q[0] ? (p50_q & n50_q) : p50_q;
  assign tick       = tick_q;
  assign pend       = pend_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: reset defaults, 33 % duty, odd 50 %,
// divide-by-200 with clamp, illegal/back-to-back loads, disabled apply and
// asynchronous reset.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] div_val;
  logic [15:0] high_val;
  logic        clk_out;
  logic        clk_out_50;
  logic        tick;
  logic        pend;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  clk_div_prog #(
    .WIDTH(16),
    .DEFAULT_DIV(32),
    .DEFAULT_HIGH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .div_val(div_val),
    .high_val(high_val),
    .clk_out(clk_out),
    .clk_out_50(clk_out_50),
    .tick(tick),
    .pend(pend),
    .err(err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges; counts ticks, clk_out-high cycles, clk_out_50-high
  // half-cycles, and tick gaps that differ from per.
  task automatic measure(input int n, input int per, output int ticks,
                         output int highs, output int h50, output int gapbad);
    int last;
    ticks = 0; highs = 0; h50 = 0; gapbad = 0; last = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        ticks++;
        if (last >= 0 && (i - last) != per) gapbad++;
        last = i;
      end
      if (clk_out) highs++;
      if (clk_out_50) h50++;
      #10;
      if (clk_out_50) h50++;
    end
  endtask

  task automatic wait_tick(input string tag, input int max);
    int found;
    found = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (tick) begin
        found = 1;
        break;
      end
    end
    chk(tag, found, 1);
  endtask

  initial begin
    int t, h, h5, g;
    rst = 1'b0; en = 1'b0; load = 1'b0; div_val = '0; high_val = '0;

    // Reset defaults
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_clk_out_50", clk_out_50, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pend", pend, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", dut.cnt_q, 31);
    rst = 1'b1; en = 1'b1;
    step();
    chk("first_tick", tick, 1);
    chk("first_clk_out", clk_out, 1);
    chk("first_clk_out_50", clk_out_50, 1);
    measure(64, 32, t, h, h5, g);
    chk("def_ticks", t, 2);
    chk("def_highs", h, 32);
    chk("def_h50", h5, 64);
    chk("def_gap", g, 0);
    chk("def_err", err, 0);
    chk("def_pend", pend, 0);

    // 33 % duty: load mid-period
    repeat (5) step();
    load = 1'b1; div_val = 16'd3; high_val = 16'd1;
    step();
    load = 1'b0;
    chk("d3_pend", pend, 1);
    chk("d3_err", err, 0);
    repeat (25) step();
    chk("d3_pend_hold", pend, 1);
    chk("d3_pre_clk_out", clk_out, 0);
    step();
    chk("d3_sw_tick", tick, 1);
    chk("d3_sw_clk_out", clk_out, 1);
    chk("d3_sw_pend", pend, 0);
    step();
    chk("d3_c1", clk_out, 0);
    step();
    chk("d3_c2", clk_out, 0);
    chk("d3_c2_tick", tick, 0);
    step();
    chk("d3_c3", clk_out, 1);
    chk("d3_c3_tick", tick, 1);
    measure(9, 3, t, h, h5, g);
    chk("d3_ticks", t, 3);
    chk("d3_highs", h, 3);
    chk("d3_h50", h5, 9);
    chk("d3_gap", g, 0);

    // Odd 50 %
    load = 1'b1; div_val = 16'd5; high_val = 16'd2;
    step();
    load = 1'b0;
    wait_tick("d5_wait", 10);
    chk("d5_pend", pend, 0);
    chk("d5_clk_out", clk_out, 1);
    measure(10, 5, t, h, h5, g);
    chk("d5_ticks", t, 2);
    chk("d5_highs", h, 4);
    chk("d5_h50", h5, 10);
    chk("d5_gap", g, 0);

    // Divide-by-200 with high-time clamp
    load = 1'b1; div_val = 16'd200; high_val = 16'd300;
    step();
    load = 1'b0;
    wait_tick("d200_wait", 10);
    chk("d200_high_q", dut.high_q, 199);
    measure(400, 200, t, h, h5, g);
    chk("d200_ticks", t, 2);
    chk("d200_highs", h, 398);
    chk("d200_h50", h5, 400);
    chk("d200_gap", g, 0);

    // Illegal load, then back-to-back loads (last wins)
    load = 1'b1; div_val = 16'd1; high_val = 16'd0;
    step();
    load = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_pend", pend, 0);
    measure(200, 200, t, h, h5, g);
    chk("ill_ticks", t, 1);
    chk("ill_highs", h, 199);
    load = 1'b1; div_val = 16'd8; high_val = 16'd4;
    step();
    div_val = 16'd10; high_val = 16'd5;
    step();
    load = 1'b0;
    chk("b2b_err", err, 0);
    chk("b2b_pend", pend, 1);
    wait_tick("b2b_wait", 250);
    measure(20, 10, t, h, h5, g);
    chk("b2b_ticks", t, 2);
    chk("b2b_highs", h, 10);
    chk("b2b_h50", h5, 20);
    chk("b2b_gap", g, 0);

    // Disabled apply
    en = 1'b0; load = 1'b1; div_val = 16'd4; high_val = 16'd2;
    step();
    load = 1'b0;
    chk("dis_pend", pend, 1);
    chk("dis_tick", tick, 0);
    step();
    chk("dis_apply_pend", pend, 0);
    chk("dis_apply_cnt", dut.cnt_q, 3);
    chk("dis_apply_clk_out", clk_out, 0);
    chk("dis_apply_clk_out_50", clk_out_50, 0);
    chk("dis_apply_tick", tick, 0);
    en = 1'b1;
    step();
    chk("reen_tick", tick, 1);
    chk("reen_clk_out", clk_out, 1);
    chk("reen_cnt", dut.cnt_q, 0);
    measure(8, 4, t, h, h5, g);
    chk("d4_ticks", t, 2);
    chk("d4_highs", h, 4);
    chk("d4_h50", h5, 8);
    chk("d4_gap", g, 0);

    // Asynchronous reset in the high phase
    chk("pre_rst_clk_out", clk_out, 1);
    chk("pre_rst_tick", tick, 1);
    rst = 1'b0;
    #2;
    chk("arst_clk_out", clk_out, 0);
    chk("arst_clk_out_50", clk_out_50, 0);
    chk("arst_tick", tick, 0);
    chk("arst_pend", pend, 0);
    chk("arst_cnt", dut.cnt_q, 31);
    step();
    rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
